// File: rtl/ldtu_seq_ctrl.sv
// LDTU datapath sequencer: datapath reset, calibration wait, sync-word alignment, run/test modes.
// Latency: outputs are flops loaded from the next-state decode, so they change on the same edge as state.
// Backpressure: none; SYNC holds until handshake, and CALWAIT gives up after CAL_TMO busy cycles.
module ldtu_seq_ctrl #(
  parameter int unsigned RST_LEN  = 8,
  parameter int unsigned CAL_TMO  = 1023,
  parameter logic [31:0] SYNC_PAT = 32'h5A5AF00F
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        CALIBRATION_BUSY,
  input  logic        TEST_ENABLE,
  input  logic        handshake,
  output logic        dp_reset,
  output logic        sel_atu,
  output logic        sync_insert,
  output logic [31:0] SYNC_WORD,
  output logic        ready,
  output logic [2:0]  state,
  output logic        cal_timeout_err,
  output logic [7:0]  resync_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DPRST   = 3'd1,
    S_CALWAIT = 3'd2,
    S_SYNC    = 3'd3,
    S_RUN     = 3'd4,
    S_TEST    = 3'd5,
    S_BAD6    = 3'd6,
    S_BAD7    = 3'd7
  } state_t;

  // DPRST counts down from RST_LEN-1; CALWAIT counts busy cycles up to CAL_TMO-1.
  localparam logic [9:0] RST_LOAD = 10'(RST_LEN - 1);
  localparam logic [9:0] CAL_LAST = 10'(CAL_TMO - 1);

  state_t     cur;
  state_t     nxt;
  logic [9:0] cnt;
  logic [9:0] cnt_nxt;
  logic       err_nxt;
  logic [7:0] rsc_nxt;

  assign state = cur;

  // State, dwell counter, sticky error and resequence counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cur             <= S_IDLE;
      cnt             <= '0;
      cal_timeout_err <= 1'b0;
      resync_cnt      <= '0;
    end else begin
      cur             <= nxt;
      cnt             <= cnt_nxt;
      cal_timeout_err <= err_nxt;
      resync_cnt      <= rsc_nxt;
    end
  end

  // Next-state logic; calibration busy always wins over handshake, test and start.
  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    err_nxt = cal_timeout_err;
    rsc_nxt = resync_cnt;
    case (cur)
      S_IDLE: begin
        if (START) begin
          nxt     = S_DPRST;
          cnt_nxt = RST_LOAD;
          err_nxt = 1'b0;
        end
      end
      S_DPRST: begin
        if (cnt == '0) begin
          nxt     = S_CALWAIT;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt - 10'd1;
        end
      end
      S_CALWAIT: begin
        if (!CALIBRATION_BUSY) begin
          nxt     = S_SYNC;
          cnt_nxt = '0;
          if (resync_cnt != 8'hFF) rsc_nxt = resync_cnt + 8'd1;
        end else if (cnt == CAL_LAST) begin
          nxt     = S_IDLE;
          cnt_nxt = '0;
          err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 10'd1;
        end
      end
      S_SYNC: begin
        if (CALIBRATION_BUSY) begin
          nxt     = S_CALWAIT;
          cnt_nxt = '0;
        end else if (handshake) begin
          nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (CALIBRATION_BUSY) begin
          nxt     = S_CALWAIT;
          cnt_nxt = '0;
        end else if (TEST_ENABLE) begin
          nxt = S_TEST;
        end else if (START) begin
          nxt     = S_DPRST;
          cnt_nxt = RST_LOAD;
        end
      end
      S_TEST: begin
        if (!TEST_ENABLE) begin
          nxt     = S_DPRST;
          cnt_nxt = RST_LOAD;
        end
      end
      default: begin
        nxt     = S_IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  // Registered Moore decode of the state being entered, so outputs line up with state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dp_reset    <= 1'b1;
      sel_atu     <= 1'b0;
      sync_insert <= 1'b0;
      SYNC_WORD   <= '0;
      ready       <= 1'b0;
    end else begin
      dp_reset    <= (nxt == S_IDLE) || (nxt == S_DPRST) ||
                     (nxt == S_CALWAIT) || (nxt == S_TEST);
      sel_atu     <= (nxt == S_TEST);
      sync_insert <= (nxt == S_SYNC);
      SYNC_WORD   <= (nxt == S_SYNC) ? SYNC_PAT : 32'h0;
      ready       <= (nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_ldtu_seq_ctrl.sv
// Bench for ldtu_seq_ctrl: cycle-by-cycle model compare plus directed literal checks.
// Inputs change and outputs are sampled on the falling clock edge.
// Runs nominal, test-mode, priority, timeout, reset-in-sync and saturation scenarios.
module tb_ldtu_seq_ctrl;

  localparam int RST_LEN = 8;
  localparam int CAL_TMO = 16;
  localparam logic [31:0] PAT = 32'h5A5AF00F;
  localparam logic [47:0] RST_VEC = 48'h8000_0000_0000;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        CALIBRATION_BUSY;
  logic        TEST_ENABLE;
  logic        handshake;
  logic        dp_reset;
  logic        sel_atu;
  logic        sync_insert;
  logic [31:0] SYNC_WORD;
  logic        ready;
  logic [2:0]  state;
  logic        cal_timeout_err;
  logic [7:0]  resync_cnt;

  int n_pass  = 0;
  int n_total = 0;

  ldtu_seq_ctrl #(.RST_LEN(RST_LEN), .CAL_TMO(CAL_TMO), .SYNC_PAT(PAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .CALIBRATION_BUSY(CALIBRATION_BUSY),
    .TEST_ENABLE(TEST_ENABLE), .handshake(handshake), .dp_reset(dp_reset),
    .sel_atu(sel_atu), .sync_insert(sync_insert), .SYNC_WORD(SYNC_WORD),
    .ready(ready), .state(state), .cal_timeout_err(cal_timeout_err),
    .resync_cnt(resync_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: current mode, cycles spent in it, resequence count, sticky error.
  typedef struct {
    int st;
    int dwell;
    int rsc;
    bit err;
  } model_t;

  model_t m = '{0, 0, 0, 1'b0};

  function automatic model_t step(model_t c, logic st, logic bz, logic te, logic hs);
    model_t n = c;
    int ns = c.st;
    case (c.st)
      0: if (st) begin ns = 1; n.err = 1'b0; end
      1: if (c.dwell + 1 >= RST_LEN) ns = 2;
      2: begin
        if (!bz) begin
          ns = 3;
          if (c.rsc < 255) n.rsc = c.rsc + 1;
        end else if (c.dwell + 1 >= CAL_TMO) begin
          ns = 0;
          n.err = 1'b1;
        end
      end
      3: if (bz) ns = 2; else if (hs) ns = 4;
      4: if (bz) ns = 2; else if (te) ns = 5; else if (st) ns = 1;
      5: if (!te) ns = 1;
      default: ns = 0;
    endcase
    n.dwell = (ns == c.st) ? c.dwell + 1 : 0;
    n.st = ns;
    return n;
  endfunction

  function automatic logic [47:0] exp_vec(model_t c);
    logic dp = (c.st == 0) || (c.st == 1) || (c.st == 2) || (c.st == 5);
    logic ins = (c.st == 3);
    logic [2:0] s3 = 3'(c.st);
    logic [7:0] r8 = 8'(c.rsc);
    return {dp, c.st == 5, ins, c.st == 4, s3, c.err, r8, ins ? PAT : 32'h0};
  endfunction

  function automatic logic [47:0] dut_vec();
    return {dp_reset, sel_atu, sync_insert, ready, state, cal_timeout_err, resync_cnt, SYNC_WORD};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Advance the model on the same edge the DUT samples.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m <= '{0, 0, 0, 1'b0};
    else m <= step(m, START, CALIBRATION_BUSY, TEST_ENABLE, handshake);
  end

  // Every cycle: DUT outputs must match the model.
  always @(negedge CLK) chk("cycle", dut_vec(), exp_vec(m));

  task automatic wait_state(input int s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (state == 3'(s)) break;
    end
    chk(name, 48'(state), 48'(s));
  endtask

  int dp_cnt, sel_cnt, seldp_cnt, dprst_cnt, cw_cnt;
  int first_sync, last_sync, first_ready;
  logic [31:0] sw_mid;

  initial begin
    START = 0; CALIBRATION_BUSY = 0; TEST_ENABLE = 0; handshake = 0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_vals", dut_vec(), RST_VEC);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_no_start", 48'(state), 48'd0);

    // Nominal path: START in cycle 0, handshake in cycle 20.
    START = 1;
    dp_cnt = 0; first_sync = -1; last_sync = -1; first_ready = -1; sw_mid = '0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge CLK);
      if (dp_reset) dp_cnt++;
      if (sync_insert) begin
        if (first_sync < 0) first_sync = c;
        last_sync = c;
      end
      if (c == 15) sw_mid = SYNC_WORD;
      if (ready && first_ready < 0) first_ready = c;
      START = 0;
      handshake = (c == 20);
    end
    chk("nom_dp_cycles", 48'(dp_cnt), 48'd9);
    chk("nom_sync_first", 48'(first_sync), 48'd10);
    chk("nom_sync_last", 48'(last_sync), 48'd20);
    chk("nom_sync_word", 48'(sw_mid), 48'h5A5AF00F);
    chk("nom_ready_first", 48'(first_ready), 48'd21);
    chk("nom_resync", 48'(resync_cnt), 48'd1);

    // Test mode: TEST_ENABLE high for five cycles from RUN.
    TEST_ENABLE = 1;
    sel_cnt = 0; seldp_cnt = 0; dprst_cnt = 0; first_sync = -1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge CLK);
      if (sel_atu) sel_cnt++;
      if (sel_atu && dp_reset) seldp_cnt++;
      if (state == 3'd1) dprst_cnt++;
      if (sync_insert && first_sync < 0) first_sync = t;
      TEST_ENABLE = (t < 5);
    end
    chk("test_sel_cycles", 48'(sel_cnt), 48'd5);
    chk("test_seldp_cycles", 48'(seldp_cnt), 48'd5);
    chk("test_dprst_cycles", 48'(dprst_cnt), 48'd8);
    chk("test_sync_first", 48'(first_sync), 48'd15);
    chk("test_resync", 48'(resync_cnt), 48'd2);
    handshake = 1;
    @(negedge CLK);
    handshake = 0;
    chk("back_to_run", 48'(state), 48'd4);

    // Simultaneous busy/test/start in RUN: calibration wins.
    CALIBRATION_BUSY = 1; TEST_ENABLE = 1; START = 1;
    @(negedge CLK);
    TEST_ENABLE = 0; START = 0;
    chk("prio_state", 48'(state), 48'd2);
    chk("prio_sel", 48'(sel_atu), 48'd0);

    // Busy held: timeout after CAL_TMO cycles in CALWAIT.
    cw_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (state == 3'd2) cw_cnt++;
      else break;
    end
    chk("tmo_cycles", 48'(cw_cnt), 48'd16);
    chk("tmo_state", 48'(state), 48'd0);
    chk("tmo_err", 48'(cal_timeout_err), 48'd1);
    TEST_ENABLE = 1; handshake = 1;
    repeat (5) @(negedge CLK);
    chk("tmo_err_sticky", 48'({state, cal_timeout_err}), 48'h1);
    TEST_ENABLE = 0; handshake = 0; CALIBRATION_BUSY = 0;
    START = 1;
    @(negedge CLK);
    START = 0;
    chk("start_clears_err", 48'({state, cal_timeout_err}), 48'h2);

    // Reset asserted in the middle of SYNC.
    wait_state(3, 30, "reach_sync");
    #2 RST_N = 1'b0;
    #1 chk("async_reset", dut_vec(), RST_VEC);
    @(negedge CLK);
    RST_N = 1'b1;
    handshake = 1;
    repeat (4) @(negedge CLK);
    handshake = 0;
    chk("hs_no_start", 48'({state, resync_cnt}), 48'h0);

    // Saturation: bounce SYNC <-> CALWAIT for well over 255 resequences.
    START = 1;
    @(negedge CLK);
    START = 0;
    wait_state(3, 30, "sat_reach_sync");
    for (int i = 0; i < 700; i++) begin
      CALIBRATION_BUSY = (state == 3'd3);
      @(negedge CLK);
    end
    CALIBRATION_BUSY = 0;
    chk("resync_sat", 48'(resync_cnt), 48'd255);

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ldtu_seq_ctrl.md
LDTU_SEQ_CTRL -- requirements
Module: ldtu_seq_ctrl

Interface
REQ-001 Parameter RST_LEN, default 8: cycles spent in DPRST, legal range 1..255.
REQ-002 Parameter CAL_TMO, default 1023: maximum cycles in CALWAIT with CALIBRATION_BUSY high, legal range 1..1023, 10-bit counter.
REQ-003 Parameter SYNC_PAT, default 32'h5A5AF00F: alignment word driven in SYNC.
REQ-004 CLK  in  1  single clock; every flop SHALL be on CLK.
REQ-005 RST_N  in  1  reset is asynchronous and active-low.
REQ-006 START  in  1  level, sampled each edge; requests a full datapath resequence.
REQ-007 CALIBRATION_BUSY  in  1  ADC calibration in progress.
REQ-008 TEST_ENABLE  in  1  ATU test-pattern mode request.
REQ-009 handshake  in  1  back-end alignment acknowledge.
REQ-010 dp_reset  out  1  active-high reset to the DTU datapath.
REQ-011 sel_atu  out  1  output mux select: 1 = ATU lanes, 0 = DTU.
REQ-012 sync_insert  out  1  high while SYNC_WORD replaces DTU data.
REQ-013 SYNC_WORD  out  32  SYNC_PAT while sync_insert is 1, else 0.
REQ-014 ready  out  1  high in RUN only.
REQ-015 state  out  3  encoded current state.
REQ-016 cal_timeout_err  out  1  sticky calibration-timeout flag.
REQ-017 resync_cnt  out  8  saturating count of SYNC entries.

Function
REQ-018 State encoding SHALL be IDLE=0, DPRST=1, CALWAIT=2, SYNC=3, RUN=4, TEST=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-019 All outputs SHALL be registered Moore decodes of state, with no combinational input-to-output path.
REQ-020 Outputs SHALL decode per state as follows.
- dp_reset = 1 in IDLE, DPRST, CALWAIT, TEST; 0 in SYNC and RUN.
- sel_atu = 1 in TEST only.
- sync_insert = 1 in SYNC only.
REQ-021 IDLE: START=1 -> DPRST, load cnt = RST_LEN-1, clear cal_timeout_err.
REQ-022 DPRST: decrement cnt each cycle; cnt=0 -> CALWAIT with cnt cleared, giving exactly RST_LEN cycles in DPRST.
REQ-023 CALWAIT, CALIBRATION_BUSY=0 -> SYNC and increment resync_cnt, saturating at 255.
REQ-024 CALWAIT, CALIBRATION_BUSY=1 -> increment cnt; when cnt reaches CAL_TMO-1 -> IDLE and set cal_timeout_err.
- Resulting CALWAIT dwell: exactly CAL_TMO cycles.
REQ-025 SYNC: handshake=1 -> RUN; otherwise stay with no timeout.
REQ-026 SYNC: CALIBRATION_BUSY=1 -> CALWAIT with cnt cleared; takes priority over handshake.
REQ-027 RUN priority, highest first:
- CALIBRATION_BUSY=1 -> CALWAIT, cnt cleared.
- TEST_ENABLE=1 -> TEST.
- START=1 -> DPRST, cnt = RST_LEN-1.
REQ-028 TEST: TEST_ENABLE=0 -> DPRST with cnt = RST_LEN-1; return to RUN only through the full sequence.
REQ-029 START in DPRST, CALWAIT or SYNC SHALL be ignored.
REQ-030 TEST_ENABLE outside RUN SHALL be ignored.
REQ-031 cal_timeout_err SHALL clear only on reset or on START accepted in IDLE.

Reset
REQ-032 While RST_N=0, all outputs SHALL hold their reset values.
- state=IDLE, dp_reset=1, sel_atu=0, sync_insert=0, SYNC_WORD=0, ready=0.
- cal_timeout_err=0, resync_cnt=0, cnt=0.
REQ-033 RST_N deassertion mid-sequence SHALL resume from IDLE; no partial count is retained.
REQ-034 No state SHALL be left without START after reset.

Verification
REQ-035 Nominal path: RST_LEN=8; START pulse at cycle 0; CALIBRATION_BUSY=0; handshake at cycle 20.
- dp_reset high for 9 cycles.
- SYNC_WORD=5A5AF00F from cycle 10 to 20.
- ready=1 from cycle 21.
- resync_cnt=1.
REQ-036 Calibration timeout: CAL_TMO=16, CALIBRATION_BUSY held high.
- 16 cycles in CALWAIT, then state=0.
- cal_timeout_err=1, and it stays 1 until the next START.
REQ-037 Test mode: in RUN, TEST_ENABLE=1 for 5 cycles.
- sel_atu=1 and dp_reset=1 for those 5 cycles.
- Then DPRST for RST_LEN cycles, then SYNC again; resync_cnt increments.
REQ-038 Simultaneous requests in RUN: CALIBRATION_BUSY=1, TEST_ENABLE=1 and START=1 on the same edge.
- state=2 and sel_atu=0.
REQ-039 Reset during SYNC: RST_N low for 1 cycle.
- All outputs return to the REQ-032 values asynchronously.
- A later handshake without START leaves state=0.
REQ-040 resync_cnt saturation: 300 resequences -> resync_cnt=255.
